led_pattern_ctrl: RTL and testbench

Parametrised multi-channel LED pattern generator. It succeeds the fixed flash/run LED pair with a single block offering N channels, a runtime-selectable mode (off, flash, run, bounce), direction and step-period control. It sits between the board clock/reset and the LED pins, and exposes a step strobe so other logic can synchronise to the pattern.

---
 rtl/led_pattern_ctrl.sv | 119 +++++++++++
 tb/tb_led_pattern_ctrl.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl -- N-channel LED pattern generator (off / flash / run / bounce) with step strobe.
// Rev 1.0
`default_nettype none

module led_pattern_ctrl #(
    parameter int LED_NUM  = 8,
    parameter int TICK_DIV = 50000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               enable,
    input  logic [1:0]         mode,
    input  logic               dir,
    input  logic [7:0]         period,
    output logic [LED_NUM-1:0] led_out,
    output logic               step_pulse
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_MAX = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        MODE_OFF    = 2'd0,
        MODE_FLASH  = 2'd1,
        MODE_RUN    = 2'd2,
        MODE_BOUNCE = 2'd3
    } mode_t;

    mode_t              mode_q, mode_q_d;
    logic [PW-1:0]      presc, presc_d;
    logic [7:0]         step_cnt, step_cnt_d;
    logic [LED_NUM-1:0] led_d;
    logic               pulse_d;
    logic               bounce_up, bounce_up_d;

    logic [7:0]         period_m1;
    logic               tick;
    logic               step_fire;

    // Period of 0 behaves as 1, so the step threshold (P-1) is 0 in both cases.
    assign period_m1 = (period == 8'd0) ? 8'd0 : (period - 8'd1);
    assign tick      = enable && (presc == TICK_MAX);
    assign step_fire = tick && (step_cnt >= period_m1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q     <= MODE_OFF;
            presc      <= '0;
            step_cnt   <= '0;
            led_out    <= '0;
            step_pulse <= 1'b0;
            bounce_up  <= 1'b1;
        end else begin
            mode_q     <= mode_q_d;
            presc      <= presc_d;
            step_cnt   <= step_cnt_d;
            led_out    <= led_d;
            step_pulse <= pulse_d;
            bounce_up  <= bounce_up_d;
        end
    end

    always_comb begin
        mode_q_d    = mode_q;
        presc_d     = presc;
        step_cnt_d  = step_cnt;
        led_d       = led_out;
        pulse_d     = 1'b0;
        bounce_up_d = bounce_up;

        if (mode != mode_q) begin
            // Restart wins over Enable and over any step landing on this edge.
            mode_q_d    = mode_t'(mode);
            presc_d     = '0;
            step_cnt_d  = '0;
            bounce_up_d = 1'b1;
            case (mode_t'(mode))
                MODE_OFF:    led_d = '0;
                MODE_FLASH:  led_d = '1;
                MODE_RUN:    led_d = dir ? (LED_NUM'(1) << (LED_NUM - 1)) : LED_NUM'(1);
                MODE_BOUNCE: led_d = LED_NUM'(1);
                default:     led_d = '0;
            endcase
        end else if (enable) begin
            presc_d = tick ? '0 : (presc + 1'b1);
            if (tick) begin
                step_cnt_d = step_fire ? 8'd0 : (step_cnt + 8'd1);
            end
            if (step_fire && (mode_q != MODE_OFF)) begin
                pulse_d = 1'b1;
                case (mode_q)
                    MODE_FLASH: led_d = ~led_out;
                    MODE_RUN: begin
                        if (dir) led_d = {led_out[0], led_out[LED_NUM-1:1]};
                        else     led_d = {led_out[LED_NUM-2:0], led_out[LED_NUM-1]};
                    end
                    MODE_BOUNCE: begin
                        // Turn around at either end so no end position is shown twice.
                        if (bounce_up && led_out[LED_NUM-1]) begin
                            bounce_up_d = 1'b0;
                            led_d       = led_out >> 1;
                        end else if (!bounce_up && led_out[0]) begin
                            bounce_up_d = 1'b1;
                            led_d       = led_out << 1;
                        end else if (bounce_up) begin
                            led_d = led_out << 1;
                        end else begin
                            led_d = led_out >> 1;
                        end
                    end
                    default: led_d = '0;
                endcase
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl -- directed self-checking bench for led_pattern_ctrl (LED_NUM=4, TICK_DIV=4).
// Rev 1.0
`default_nettype none

module tb_led_pattern_ctrl;

    localparam int LED_NUM  = 4;
    localparam int TICK_DIV = 4;

    logic               clk;
    logic               rst;
    logic               enable;
    logic [1:0]         mode;
    logic               dir;
    logic [7:0]         period;
    logic [LED_NUM-1:0] led_out;
    logic               step_pulse;

    int passed = 0;
    int total  = 0;

    led_pattern_ctrl #(
        .LED_NUM  (LED_NUM),
        .TICK_DIV (TICK_DIV)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .dir        (dir),
        .period     (period),
        .led_out    (led_out),
        .step_pulse (step_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Waits gap cycles: LED holds prev with no strobe, then shows nxt with the strobe.
    task automatic expect_step(input string tag, input logic [3:0] prev, input logic [3:0] nxt,
                               input int gap);
        for (int i = 0; i < gap - 1; i++) begin
            tick1();
            check({tag, "_hold_led"}, {4'b0, led_out}, {4'b0, prev});
            check({tag, "_hold_pulse"}, {7'b0, step_pulse}, 8'd0);
        end
        tick1();
        check({tag, "_step_led"}, {4'b0, led_out}, {4'b0, nxt});
        check({tag, "_step_pulse"}, {7'b0, step_pulse}, 8'd1);
    endtask

    initial begin
        rst    = 1'b1;
        enable = 1'b1;
        mode   = 2'd0;
        dir    = 1'b0;
        period = 8'd2;
        repeat (3) tick1();
        check("reset_led", {4'b0, led_out}, 8'd0);
        check("reset_pulse", {7'b0, step_pulse}, 8'd0);
        rst = 1'b0;
        tick1();
        check("post_reset_led", {4'b0, led_out}, 8'd0);

        // Run left, Period=2 -> 8 cycles per step
        mode = 2'd2;
        tick1();
        check("runl_init", {4'b0, led_out}, 8'b0001);
        check("runl_init_pulse", {7'b0, step_pulse}, 8'd0);
        expect_step("runl1", 4'b0001, 4'b0010, 8);
        expect_step("runl2", 4'b0010, 4'b0100, 8);
        expect_step("runl3", 4'b0100, 4'b1000, 8);
        expect_step("runl4", 4'b1000, 4'b0001, 8);

        // Run right: pass through off to force a restart
        mode = 2'd0;
        tick1();
        check("off_led", {4'b0, led_out}, 8'd0);
        mode = 2'd2;
        dir  = 1'b1;
        tick1();
        check("runr_init", {4'b0, led_out}, 8'b1000);
        expect_step("runr1", 4'b1000, 4'b0100, 8);
        expect_step("runr2", 4'b0100, 4'b0010, 8);
        expect_step("runr3", 4'b0010, 4'b0001, 8);
        expect_step("runr4", 4'b0001, 4'b1000, 8);

        // Bounce, Period=1
        mode   = 2'd3;
        period = 8'd1;
        tick1();
        check("bnc_init", {4'b0, led_out}, 8'b0001);
        expect_step("bnc1", 4'b0001, 4'b0010, 4);
        expect_step("bnc2", 4'b0010, 4'b0100, 4);
        expect_step("bnc3", 4'b0100, 4'b1000, 4);
        expect_step("bnc4", 4'b1000, 4'b0100, 4);
        expect_step("bnc5", 4'b0100, 4'b0010, 4);
        expect_step("bnc6", 4'b0010, 4'b0001, 4);
        expect_step("bnc7", 4'b0001, 4'b0010, 4);

        // Flash, Period=0 behaves as 1
        mode   = 2'd1;
        period = 8'd0;
        tick1();
        check("fl_init", {4'b0, led_out}, 8'b1111);
        expect_step("fl1", 4'b1111, 4'b0000, 4);
        expect_step("fl2", 4'b0000, 4'b1111, 4);
        expect_step("fl3", 4'b1111, 4'b0000, 4);

        // Freeze mid-step in run mode, Period=2
        mode   = 2'd2;
        dir    = 1'b0;
        period = 8'd2;
        tick1();
        check("frz_init", {4'b0, led_out}, 8'b0001);
        repeat (3) tick1();
        check("frz_pre", {4'b0, led_out}, 8'b0001);
        enable = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick1();
            check("frz_hold_led", {4'b0, led_out}, 8'b0001);
            check("frz_hold_pulse", {7'b0, step_pulse}, 8'd0);
        end
        enable = 1'b1;
        expect_step("frz_resume", 4'b0001, 4'b0010, 5);

        // Mode change while frozen still restarts
        enable = 1'b0;
        tick1();
        mode = 2'd3;
        tick1();
        check("frz_mode_led", {4'b0, led_out}, 8'b0001);
        check("frz_mode_pulse", {7'b0, step_pulse}, 8'd0);
        repeat (6) tick1();
        check("frz_mode_hold", {4'b0, led_out}, 8'b0001);

        // Async reset while LED_Out=0100
        enable = 1'b1;
        mode   = 2'd2;
        period = 8'd1;
        tick1();
        check("ar_init", {4'b0, led_out}, 8'b0001);
        expect_step("ar1", 4'b0001, 4'b0010, 4);
        expect_step("ar2", 4'b0010, 4'b0100, 4);
        #2;
        rst  = 1'b1;
        mode = 2'd0;
        #1;
        check("ar_led_now", {4'b0, led_out}, 8'd0);
        check("ar_pulse_now", {7'b0, step_pulse}, 8'd0);
        tick1();
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick1();
            check("ar_after_led", {4'b0, led_out}, 8'd0);
            check("ar_after_pulse", {7'b0, step_pulse}, 8'd0);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

`default_nettype wire
